// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and subordinate state type.
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } sub_state_e;

endpackage

// File: rtl/ahb_sub_mem.sv
// Word-organised SRAM array: byte-enabled synchronous write,
// asynchronous read at the same word index.
module ahb_sub_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate with wait states and lane steering.
// Define AHB_SUB_ERR_RESP_EN for the two-cycle ERROR response.
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  i_mngr_sub_unsign,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  sub_state_e state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [2:0]    size_q;
  logic          wr_q, uns_q, ill_q;

  logic [ADDR_WIDTH:0] off;
  logic in_range, bad_align, illegal, accept;
  logic we;
  logic [3:0] be;
  logic [31:0] rd, sh_b, sh_h, ext;
  logic unused_bits;

  // A borrow in off pushes below-base addresses past LIMIT too
  assign off      = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign in_range = off < LIMIT;
  assign bad_align = (HSIZE == SIZE_HALF && HADDR[0]) ||
                     (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00);
  assign illegal  = (HSIZE > SIZE_WORD) || bad_align || !in_range;
  assign accept   = HSEL && HTRANS[1] && HREADY && HREADYOUT;

  assign unused_bits = ^{HBURST, HPROT, HTRANS[0], off};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      lane_q <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
      uns_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q  <= off[AW+1:2];
        lane_q <= HADDR[1:0];
        size_q <= HSIZE;
        wr_q   <= HWRITE;
        uns_q  <= i_mngr_sub_unsign;
        ill_q  <= illegal;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_WAIT: begin
        if (cnt == 4'd0) state_n = S_DATA;
        else cnt_n = cnt - 4'd1;
      end
`ifdef AHB_SUB_ERR_RESP_EN
      S_ERR1: state_n = S_ERR2;
`endif
      default: begin
        state_n = S_IDLE;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = WS - 4'd1;
          end else begin
            state_n = S_DATA;
          end
`ifdef AHB_SUB_ERR_RESP_EN
          if (illegal) state_n = S_ERR1;
`endif
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    unique case (state)
      S_WAIT: HREADYOUT = 1'b0;
`ifdef AHB_SUB_ERR_RESP_EN
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
      end
      S_ERR2: HRESP = RESP_ERROR;
`endif
      default: ;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      SIZE_BYTE: be = 4'b0001 << lane_q;
      SIZE_HALF: be = lane_q[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
  end

  assign we = (state == S_DATA) && wr_q && !ill_q;

  ahb_sub_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .we    (we),
    .be    (be),
    .addr  (idx_q),
    .wdata (HWDATA[31:0]),
    .rdata (rd)
  );

  assign sh_b = rd >> {lane_q, 3'b000};
  assign sh_h = rd >> {lane_q[1], 4'b0000};

  always_comb begin
    ext = rd;
    unique case (size_q)
      SIZE_BYTE: ext = {{24{~uns_q & sh_b[7]}}, sh_b[7:0]};
      SIZE_HALF: ext = {{16{~uns_q & sh_h[15]}}, sh_h[15:0]};
      default:   ext = rd;
    endcase
  end

  assign HRDATA = (state == S_DATA && !ill_q) ? DATA_WIDTH'(ext) : '0;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: zero-wait and three-wait-state instances on shared stimulus.
module tb_ahb_sram_subordinate;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel0 = 1'b0, sel3 = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = TRANS_IDLE;
  logic hwrite = 1'b0, uns = 1'b0;
  logic [2:0] hsize = SIZE_WORD;
  logic rdy0, resp0, rdy3, resp3;
  logic [31:0] rdata0, rdata3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(hwdata),
    .HREADY(rdy0), .i_mngr_sub_unsign(uns),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_subordinate #(.WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata),
    .HREADY(rdy3), .i_mngr_sub_unsign(uns),
    .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input bit d3, input logic [31:0] a,
                            input bit w, input logic [2:0] sz, input bit u);
    sel0 = !d3; sel3 = d3;
    haddr = a; htrans = TRANS_NONSEQ;
    hwrite = w; hsize = sz; uns = u;
  endtask

  task automatic go_idle();
    sel0 = 1'b0; sel3 = 1'b0; htrans = TRANS_IDLE;
  endtask

  task automatic do_xfer(input bit d3, input logic [31:0] a, input bit w,
                         input logic [2:0] sz, input bit u, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err, output int cyc);
    addr_phase(d3, a, w, sz, u);
    tick();
    go_idle();
    hwdata = wd;
    err = 1'b0; cyc = 0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      cyc++;
      if (d3 ? resp3 : resp0) err = 1'b1;
      if (d3 ? rdy3 : rdy0) begin
        rd = d3 ? rdata3 : rdata0;
        tick();
        return;
      end
      tick();
    end
    tests_run++; tests_failed++;
    $display("FAIL xfer_timeout: addr %h no HREADYOUT within 20 cycles", a);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({rdy0, resp0, rdy3, resp3} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_ready_resp: got %b expected 1010",
               {rdy0, resp0, rdy3, resp3});
    end
    tests_run++;
    if (rdata0 !== 32'h0 || rdata3 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h/%h expected 0", rdata0, rdata3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_non_transfer();
    sel0 = 1'b1; htrans = TRANS_BUSY; haddr = 32'h10; hwrite = 1'b0;
    tick();
    htrans = TRANS_IDLE;
    tick();
    tests_run++;
    if ({rdy0, resp0} !== 2'b10 || rdata0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL busy_idle: got rdy %b resp %b data %h expected 1 0 0",
               rdy0, resp0, rdata0);
    end
    go_idle();
    tick();
  endtask

  task automatic test_word_rw();
    addr_phase(0, 32'h10, 1, SIZE_WORD, 0);
    tick();
    hwdata = 32'hDEADBEEF;
    addr_phase(0, 32'h10, 0, SIZE_WORD, 0);
    tests_run++;
    if (rdy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL word_wr_ready: got %b expected 1", rdy0);
    end
    tick();
    go_idle();
    hwdata = '0;
    tests_run++;
    if (rdy0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL word_raw: got rdy %b data %h expected 1 deadbeef",
               rdy0, rdata0);
    end
    tick();
  endtask

  task automatic test_byte_sign();
    logic [31:0] rd;
    bit err;
    int cyc;
    do_xfer(0, 32'h20, 1, SIZE_WORD, 0, 32'h000080FF, rd, err, cyc);
    do_xfer(0, 32'h21, 0, SIZE_BYTE, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'hFFFFFF80) begin
      tests_failed++;
      $display("FAIL byte_signed: got %h expected ffffff80", rd);
    end
    do_xfer(0, 32'h21, 0, SIZE_BYTE, 1, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL byte_unsigned: got %h expected 00000080", rd);
    end
    do_xfer(0, 32'h20, 0, SIZE_BYTE, 1, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h000000FF) begin
      tests_failed++;
      $display("FAIL byte0_unsigned: got %h expected 000000ff", rd);
    end
    do_xfer(0, 32'h20, 0, SIZE_HALF, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'hFFFF80FF) begin
      tests_failed++;
      $display("FAIL half_signed: got %h expected ffff80ff", rd);
    end
  endtask

  task automatic test_half_lane();
    logic [31:0] rd;
    bit err;
    int cyc;
    do_xfer(0, 32'h20, 1, SIZE_WORD, 0, 32'hAAAAAAAA, rd, err, cyc);
    do_xfer(0, 32'h22, 1, SIZE_HALF, 0, 32'h12340000, rd, err, cyc);
    do_xfer(0, 32'h20, 0, SIZE_WORD, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h1234AAAA) begin
      tests_failed++;
      $display("FAIL half_lane: got %h expected 1234aaaa", rd);
    end
    do_xfer(0, 32'h20, 1, SIZE_BYTE, 0, 32'h1111115A, rd, err, cyc);
    do_xfer(0, 32'h20, 0, SIZE_WORD, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h1234AA5A) begin
      tests_failed++;
      $display("FAIL byte_lane: got %h expected 1234aa5a", rd);
    end
    do_xfer(0, 32'h22, 0, SIZE_HALF, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h00001234) begin
      tests_failed++;
      $display("FAIL half_upper_read: got %h expected 00001234", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [4];
    pat = '{32'h11110000, 32'h22220101, 32'h33330202, 32'h44440303};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) addr_phase(0, 32'h50 + 32'(4*i), 1, SIZE_WORD, 0);
      else go_idle();
      if (i > 0) begin
        hwdata = pat[i-1];
        tests_run++;
        if (rdy0 !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_wr_ready[%0d]: got %b expected 1", i-1, rdy0);
        end
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) addr_phase(0, 32'h50 + 32'(4*i), 0, SIZE_WORD, 0);
      else go_idle();
      if (i > 0) begin
        tests_run++;
        if (rdy0 !== 1'b1 || rdata0 !== pat[i-1]) begin
          tests_failed++;
          $display("FAIL b2b_rd[%0d]: got rdy %b data %h expected 1 %h",
                   i-1, rdy0, rdata0, pat[i-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    bit err;
    int cyc;
    do_xfer(1, 32'h40, 1, SIZE_WORD, 0, 32'hCAFEF00D, rd, err, cyc);
    tests_run++;
    if (cyc !== 4 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ws_write_len: got %0d cycles err %b expected 4 0", cyc, err);
    end
    addr_phase(1, 32'h40, 0, SIZE_WORD, 0);
    tick();
    go_idle();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rdy3 !== (i == 3) ||
          rdata3 !== ((i == 3) ? 32'hCAFEF00D : 32'h0)) begin
        tests_failed++;
        $display("FAIL ws_read_cycle[%0d]: got rdy %b data %h", i, rdy3, rdata3);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    bit err;
    int cyc;
    do_xfer(0, 32'h00, 1, SIZE_WORD, 0, 32'h01234567, rd, err, cyc);
`ifdef AHB_SUB_ERR_RESP_EN
    addr_phase(0, 32'h02, 1, SIZE_WORD, 0);
    tick();
    go_idle();
    hwdata = 32'hFFFFFFFF;
    tests_run++;
    if ({rdy0, resp0} !== 2'b01) begin
      tests_failed++;
      $display("FAIL err1_wr: got rdy/resp %b expected 01", {rdy0, resp0});
    end
    tick();
    tests_run++;
    if ({rdy0, resp0} !== 2'b11) begin
      tests_failed++;
      $display("FAIL err2_wr: got rdy/resp %b expected 11", {rdy0, resp0});
    end
    tick();
    addr_phase(0, 32'h1000, 0, SIZE_WORD, 0);
    tick();
    go_idle();
    tests_run++;
    if ({rdy0, resp0} !== 2'b01 || rdata0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL err1_rd: got %b data %h expected 01 0", {rdy0, resp0}, rdata0);
    end
    tick();
    tests_run++;
    if ({rdy0, resp0} !== 2'b11 || rdata0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL err2_rd: got %b data %h expected 11 0", {rdy0, resp0}, rdata0);
    end
    tick();
    do_xfer(1, 32'h01, 0, SIZE_HALF, 0, 0, rd, err, cyc);
    tests_run++;
    if (cyc !== 2 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ws_err_len: got %0d cycles err %b expected 2 1", cyc, err);
    end
`else
    do_xfer(0, 32'h02, 1, SIZE_WORD, 0, 32'hFFFFFFFF, rd, err, cyc);
    tests_run++;
    if (cyc !== 1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_wr_okay: got %0d cycles err %b expected 1 0", cyc, err);
    end
    do_xfer(0, 32'h1000, 0, SIZE_WORD, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_rd_zero: got %h err %b expected 0 0", rd, err);
    end
    do_xfer(1, 32'h01, 0, SIZE_HALF, 0, 0, rd, err, cyc);
    tests_run++;
    if (cyc !== 4 || err !== 1'b0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL ws_ill_rd: got %0d cycles err %b data %h expected 4 0 0",
               cyc, err, rd);
    end
`endif
    do_xfer(0, 32'h00, 0, SIZE_WORD, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h01234567) begin
      tests_failed++;
      $display("FAIL ill_wr_dropped: got %h expected 01234567", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit err;
    int cyc;
    do_xfer(1, 32'h60, 1, SIZE_WORD, 0, 32'h55AA55AA, rd, err, cyc);
    addr_phase(1, 32'h60, 1, SIZE_WORD, 0);
    tick();
    go_idle();
    hwdata = 32'h0;
    tests_run++;
    if (rdy3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_in_wait: got %b expected 0", rdy3);
    end
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({rdy3, resp3} !== 2'b10 || rdata3 !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %b data %h expected 10 0",
               {rdy3, resp3}, rdata3);
    end
    tick();
    rst = 1'b0;
    tick();
    do_xfer(1, 32'h60, 0, SIZE_WORD, 0, 0, rd, err, cyc);
    tests_run++;
    if (rd !== 32'h55AA55AA) begin
      tests_failed++;
      $display("FAIL mid_reset_mem: got %h expected 55aa55aa", rd);
    end
  endtask

  initial begin
    test_reset();
    test_non_transfer();
    test_word_rw();
    test_byte_sign();
    test_half_lane();
    test_back_to_back();
    test_wait_states();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
